// File: rtl/waveform_renderer.sv
// waveform_renderer
// Display-side consumer of the sample capture buffer. It drives the buffer
// column address from the current pixel position. It converts the returned
// samples into trace rows, and joins consecutive columns with vertical
// segments. It classifies each pixel as background, grid or trace, and
// publishes the per-frame min/max trace rows seen on pixel row 0.
//
// Optional feature: define TRACE_GRID_EN to draw the graticule (class 01).
// Without it no grid logic exists and pixelClass is only ever 00 or 10.
//
// Handshake: pixelValid qualifies pixelX/pixelY in the same cycle. There is no
// ready, because the renderer never stalls. pixelValidOut qualifies pixelClass
// for the pixel presented exactly three clocks earlier. Invalid cycles travel
// through as bubbles and change no state.

module waveform_renderer #(
    parameter int SAMPLE_W    = 14,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [X_W-1:0]      pixelX,
    input  logic [Y_W-1:0]      pixelY,
    input  logic                pixelValid,
    input  logic                frameStart,
    output logic [X_W-1:0]      sampleX,
    input  logic [SAMPLE_W-1:0] screenData,
    output logic [1:0]          pixelClass,
    output logic                pixelValidOut,
    output logic [Y_W-1:0]      traceMinRow,
    output logic [Y_W-1:0]      traceMaxRow
);

    localparam logic [Y_W-1:0]      ROW_MAX = Y_W'(V_ACTIVE - 1);
    localparam logic [SAMPLE_W-1:0] RAW_MAX = SAMPLE_W'(V_ACTIVE - 1);
    localparam logic [X_W-1:0]      X_LIMIT = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]      Y_LIMIT = Y_W'(V_ACTIVE);

    localparam logic [1:0] CLASS_BG    = 2'b00;
    localparam logic [1:0] CLASS_TRACE = 2'b10;
`ifdef TRACE_GRID_EN
    localparam logic [1:0]     CLASS_GRID = 2'b01;
    localparam logic [X_W-1:0] GRID_DX    = X_W'(80);
    localparam logic [Y_W-1:0] GRID_DY    = Y_W'(60);
    localparam logic [X_W-1:0] EDGE_X     = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] CENTRE_X   = X_W'(H_ACTIVE / 2);
    localparam logic [Y_W-1:0] CENTRE_Y   = Y_W'(V_ACTIVE / 2);
`endif

    // Stage 1: coordinates registered alongside the buffer address.
    logic                s1_valid_q, s1_valid_d;
    logic [X_W-1:0]      s1_x_q, s1_x_d;
    logic [Y_W-1:0]      s1_y_q, s1_y_d;

    // Stage 2: coordinates plus the sample returned for them.
    logic                s2_valid_q, s2_valid_d;
    logic [X_W-1:0]      s2_x_q, s2_x_d;
    logic [Y_W-1:0]      s2_y_q, s2_y_d;
    logic [SAMPLE_W-1:0] s2_data_q, s2_data_d;

    // Stage 3: classified output.
    logic [1:0]          pixel_class_q, pixel_class_d;
    logic                pixel_valid_out_q, pixel_valid_out_d;

    // Segment-joining context for the current line.
    logic [Y_W-1:0]      prev_row_q, prev_row_d;
    logic [X_W-1:0]      last_x_q, last_x_d;
    logic                have_prev_q, have_prev_d;

    // Frame min/max accumulators and their published copies.
    logic [Y_W-1:0]      acc_min_q, acc_min_d;
    logic [Y_W-1:0]      acc_max_q, acc_max_d;
    logic [Y_W-1:0]      pub_min_q, pub_min_d;
    logic [Y_W-1:0]      pub_max_q, pub_max_d;

    // Stage-3 intermediate values.
    logic [SAMPLE_W-1:0] raw_row;
    logic [SAMPLE_W-1:0] clamped_row;
    logic [Y_W-1:0]      row;
    logic                in_range;
    logic                live_pixel;
    logic                new_line;
    logic [Y_W-1:0]      seg_start;
    logic [Y_W-1:0]      seg_lo;
    logic [Y_W-1:0]      seg_hi;
    logic                trace_hit;
    logic                fold;
`ifdef TRACE_GRID_EN
    logic                grid_hit;
`endif

    // Stage 1: capture the incoming pixel and present its column to the buffer.
    always_comb begin
        s1_valid_d = pixelValid;
        s1_x_d     = pixelX;
        s1_y_d     = pixelY;
    end

    // Stage 2: pair the buffer read data with the stage-1 coordinates.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;
        s2_data_d  = screenData;
    end

    // Stage 3: sample-to-row mapping, segment span and pixel classification.
    always_comb begin
        // Sample 0 lands on the bottom row. Large samples saturate at the top.
        raw_row     = s2_data_q >> SCALE_SHIFT;
        clamped_row = (raw_row > RAW_MAX) ? RAW_MAX : raw_row;
        row         = ROW_MAX - Y_W'(clamped_row);

        in_range   = (s2_x_q < X_LIMIT) && (s2_y_q < Y_LIMIT);
        live_pixel = s2_valid_q && in_range;

        // A column that does not directly follow the last drawn one starts a
        // fresh line, so its segment collapses to a single dot.
        new_line  = !have_prev_q || (s2_x_q == '0) ||
                    (s2_x_q != last_x_q + X_W'(1));
        seg_start = new_line ? row : prev_row_q;
        seg_lo    = (seg_start < row) ? seg_start : row;
        seg_hi    = (seg_start < row) ? row : seg_start;
        trace_hit = (s2_y_q >= seg_lo) && (s2_y_q <= seg_hi);

`ifdef TRACE_GRID_EN
        grid_hit = ((s2_x_q % GRID_DX) == '0) || ((s2_y_q % GRID_DY) == '0) ||
                   (s2_x_q == EDGE_X) || (s2_y_q == ROW_MAX) ||
                   (s2_x_q == CENTRE_X) || (s2_y_q == CENTRE_Y);
`endif

        pixel_valid_out_d = s2_valid_q;
        pixel_class_d     = CLASS_BG;
        if (live_pixel) begin
`ifdef TRACE_GRID_EN
            pixel_class_d = trace_hit ? CLASS_TRACE : (grid_hit ? CLASS_GRID : CLASS_BG);
`else
            pixel_class_d = trace_hit ? CLASS_TRACE : CLASS_BG;
`endif
        end

        // Only in-range pixels move the line context forward.
        prev_row_d  = prev_row_q;
        last_x_d    = last_x_q;
        have_prev_d = have_prev_q;
        if (live_pixel) begin
            prev_row_d  = row;
            last_x_d    = s2_x_q;
            have_prev_d = 1'b1;
        end
    end

    // Frame statistics: fold row-0 trace rows, publish and reload on frameStart.
    always_comb begin
        fold      = live_pixel && (s2_y_q == '0);
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        pub_min_d = pub_min_q;
        pub_max_d = pub_max_q;
        if (frameStart) begin
            // A row folded in the same cycle belongs to the new frame.
            pub_min_d = acc_min_q;
            pub_max_d = acc_max_q;
            acc_min_d = fold ? row : ROW_MAX;
            acc_max_d = fold ? row : '0;
        end else if (fold) begin
            if (row < acc_min_q) acc_min_d = row;
            if (row > acc_max_q) acc_max_d = row;
        end
    end

    // State registers with synchronous active-low reset that flushes the pipeline.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q        <= 1'b0;
            s1_x_q            <= '0;
            s1_y_q            <= '0;
            s2_valid_q        <= 1'b0;
            s2_x_q            <= '0;
            s2_y_q            <= '0;
            s2_data_q         <= '0;
            pixel_class_q     <= CLASS_BG;
            pixel_valid_out_q <= 1'b0;
            prev_row_q        <= '0;
            last_x_q          <= '0;
            have_prev_q       <= 1'b0;
            acc_min_q         <= ROW_MAX;
            acc_max_q         <= '0;
            pub_min_q         <= ROW_MAX;
            pub_max_q         <= '0;
        end else begin
            s1_valid_q        <= s1_valid_d;
            s1_x_q            <= s1_x_d;
            s1_y_q            <= s1_y_d;
            s2_valid_q        <= s2_valid_d;
            s2_x_q            <= s2_x_d;
            s2_y_q            <= s2_y_d;
            s2_data_q         <= s2_data_d;
            pixel_class_q     <= pixel_class_d;
            pixel_valid_out_q <= pixel_valid_out_d;
            prev_row_q        <= prev_row_d;
            last_x_q          <= last_x_d;
            have_prev_q       <= have_prev_d;
            acc_min_q         <= acc_min_d;
            acc_max_q         <= acc_max_d;
            pub_min_q         <= pub_min_d;
            pub_max_q         <= pub_max_d;
        end
    end

    assign sampleX       = s1_x_q;
    assign pixelClass    = pixel_class_q;
    assign pixelValidOut = pixel_valid_out_q;
    assign traceMinRow   = pub_min_q;
    assign traceMaxRow   = pub_max_q;

endmodule

// File: doc/waveform_renderer.md
Name: waveform_renderer

Overview:
- Display-side consumer of the sample/trigger capture buffer: drives the buffer's column address from the current pixel position and turns the returned 14-bit samples into trace pixels.
- Sits between the VGA timing generator (pixel coordinates) and the colour mux.
- Connects consecutive columns with vertical segments so that steep edges draw as a continuous trace.
- Tracks the per-frame min/max trace rows for an on-screen readout.

Parameters:
- SAMPLE_W, 14, sample width from the capture buffer
- X_W, 11, pixel X width / buffer column address width
- Y_W, 10, pixel Y width
- H_ACTIVE, 800, visible columns
- V_ACTIVE, 480, visible rows
- SCALE_SHIFT, 5, right shift applied to a sample to obtain its raw row

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pixelX  in  X_W  current pixel column from VGA timing
- pixelY  in  Y_W  current pixel row
- pixelValid  in  1  pixelX/pixelY are meaningful this cycle
- frameStart  in  1  one-cycle pulse before the first pixel of a frame
- sampleX  out  X_W  column address to the capture buffer (registered)
- screenData  in  SAMPLE_W  buffer read data, valid 1 clock after sampleX
- pixelClass  out  2  00 background, 01 grid, 10 trace (11 never driven)
- pixelValidOut  out  1  pixelClass corresponds to a pixel issued 3 clocks earlier
- traceMinRow  out  Y_W  smallest trace row of the previous frame
- traceMaxRow  out  Y_W  largest trace row of the previous frame

Behaviour:
- Reset (reset==0 at a clock edge): all pipeline valids, sampleX, pixelClass, pixelValidOut and prevRow are cleared. traceMinRow is set to V_ACTIVE-1 and traceMaxRow to 0, as are the frame accumulators. A reset mid-line discards everything in flight; no stale pixel may emerge afterwards.
- Pipeline (fixed latency 3):
  - S1: register pixelX/Y/valid; sampleX <= pixelX.
  - S2: screenData arrives; register it together with the S1 coordinates.
  - S3: compute the row and class, and register the outputs.
- Row computation: raw = screenData >> SCALE_SHIFT. Clamp raw to V_ACTIVE-1. row = (V_ACTIVE-1) - clamped, so sample 0 maps to the bottom row. All arithmetic is unsigned at Y_W bits.
- Segment joining: prevRow holds the row of the previous valid in-range column on the same line.
  - Trace is asserted when lo <= pixelY <= hi, where lo = min(prevRow,row) and hi = max(prevRow,row).
  - On a new line, prevRow = row for that column, giving a single-pixel dot. A new line means pixelX==0 or pixelX != lastX+1.
  - prevRow updates only on valid in-range pixels.
- Out of range (pixelX >= H_ACTIVE or pixelY >= V_ACTIVE) with valid: pixelClass=00, pixelValidOut=1. prevRow and the min/max accumulators are untouched.
- pixelValid low: the bubble propagates; pixelValidOut=0, pixelClass=00, and no state updates.
- Min/max: on each valid in-range pixel with pixelY==0, fold row into the accumulators.
- frameStart:
  - The accumulated min/max are copied to the outputs one clock after the pulse, and the accumulators reload to V_ACTIVE-1 and 0.
  - If frameStart and a fold occur in the same cycle, the reload wins and the folded row seeds the new accumulators.
  - A frame with no folds publishes V_ACTIVE-1 / 0 unchanged.
- Priority: trace over grid over background.

Optional Feature:
- Macro TRACE_GRID_EN.
- Defined: grid (01) is drawn where pixelX % 80 == 0, pixelY % 60 == 0, pixelX == H_ACTIVE-1 or pixelY == V_ACTIVE-1, and trace is not asserted. Centre lines pixelX==400 and pixelY==240 are also grid.
- Undefined: no grid logic is synthesised and pixelClass is only ever 00 or 10.

Test Plan:
- Constant screenData=0, full line y=479 -> pixelClass=10 at every x<800, exactly 3 clocks after input; y=478 all 00.
- screenData=16383 -> raw 511 clamped to 479, row 0: trace only at y=0. screenData=8192 -> row 223: trace only at y=223.
- Step between x=99 (data 0, row 479) and x=100 (data 8192, row 223), scanning y=223..479 -> trace at x=100 for all of 223..479 inclusive; x=99 trace only at 479.
- pixelValid deasserted for 2 cycles mid-line -> 2-cycle pixelValidOut gap 3 clocks later; prevRow is preserved and no spurious segment is drawn.
- Frame with rows 100..300 on y=0, then frameStart -> traceMinRow=100, traceMaxRow=300 one clock later; an empty frame then publishes 479/0.
- reset=0 for 1 clock mid-line -> all outputs 00/0 for the next 3 clocks; min/max outputs read 479/0. With TRACE_GRID_EN defined, pixel (80,61) with no trace gives class 01 and (81,61) gives 00.
